// File: rtl/counter_sequencer_pkg.sv
// Shared encodings for the counter sequencer: run modes and counter direction.
package counter_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_STOP     = 2'd0,
        MODE_UP       = 2'd1,
        MODE_DOWN     = 2'd2,
        MODE_PINGPONG = 2'd3
    } mode_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic mode_t next_mode(input mode_t current);
        case (current)
            MODE_STOP:     next_mode = MODE_UP;
            MODE_UP:       next_mode = MODE_DOWN;
            MODE_DOWN:     next_mode = MODE_PINGPONG;
            default:       next_mode = MODE_STOP;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces an active-low push-button; emits a one-cycle
// press pulse when the debounced level falls.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock_5,
    input  logic reset,
    input  logic key,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             key_state;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge clock_5 or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= key;
            sync_2 <= sync_1;
        end
    end

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clock_5 or posedge reset) begin
        if (reset) begin
            key_state  <= 1'b1;
            stable_cnt <= '0;
            press      <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_2 == key_state) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                key_state  <= sync_2;
                stable_cnt <= '0;
                press      <= ~sync_2;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Control block for the 8-bit up/down counter: key-driven mode FSM,
// registered tick gating and ping-pong turnaround at the configured limits.
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 250000,
    parameter logic [7:0] LOW_LIMIT       = 8'd0,
    parameter logic [7:0] HIGH_LIMIT      = 8'd255
) (
    input  logic       clock_5,
    input  logic       reset,
    input  logic       key1,
    input  logic       tick,
    input  logic [7:0] count_in,
    output logic       up_down,
    output logic       enable_out,
    output logic [1:0] mode
);

    mode_t mode_q;
    mode_t mode_d;
    logic  dir_q;
    logic  dir_d;
    logic  enable_q;
    logic  enable_d;
    logic  press;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key1_debounce (
        .clock_5(clock_5),
        .reset  (reset),
        .key    (key1),
        .press  (press)
    );

    always_ff @(posedge clock_5 or posedge reset) begin
        if (reset) begin
            mode_q   <= MODE_STOP;
            dir_q    <= DIR_UP;
            enable_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            enable_q <= enable_d;
        end
    end

    // The tick is judged under the current mode; a simultaneous press then
    // switches mode, and a mode entry's direction takes precedence.
    always_comb begin
        mode_d   = mode_q;
        dir_d    = dir_q;
        enable_d = 1'b0;

        if (tick) begin
            case (mode_q)
                MODE_UP: begin
                    enable_d = 1'b1;
                    dir_d    = DIR_UP;
                end
                MODE_DOWN: begin
                    enable_d = 1'b1;
                    dir_d    = DIR_DOWN;
                end
                MODE_PINGPONG: begin
                    enable_d = 1'b1;
                    if (dir_q == DIR_UP && count_in >= HIGH_LIMIT) begin
                        dir_d = DIR_DOWN;
                    end else if (dir_q == DIR_DOWN && count_in <= LOW_LIMIT) begin
                        dir_d = DIR_UP;
                    end
                end
                default: enable_d = 1'b0;
            endcase
        end

        if (press) begin
            mode_d = next_mode(mode_q);
            case (mode_d)
                MODE_UP, MODE_PINGPONG: dir_d = DIR_UP;
                MODE_DOWN:              dir_d = DIR_DOWN;
                default:                dir_d = dir_d;
            endcase
        end
    end

    assign mode       = mode_q;
    assign up_down    = dir_q;
    assign enable_out = enable_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: a cycle model fills a scoreboard
// queue as stimulus is driven; DUT outputs are popped and compared at negedge.
module tb_counter_sequencer;

    localparam int         DEB  = 4;
    localparam logic [7:0] LOW  = 8'd0;
    localparam logic [7:0] HIGH = 8'd5;

    logic       clock_5 = 1'b0;
    logic       reset;
    logic       key1;
    logic       tick;
    logic [7:0] count_val = 8'd0;
    logic       up_down;
    logic       enable_out;
    logic [1:0] mode;

    typedef struct packed {
        logic [1:0] mode;
        logic       up_down;
        logic       en;
    } exp_t;

    exp_t sb_q[$];
    int   tick_counts[$];
    bit   rec_ticks = 1'b0;
    int   checks = 0;
    int   passed = 0;

    logic       m_s1, m_s2, m_deb, m_press, m_dir, m_en;
    int         m_run;
    logic [1:0] m_mode;

    counter_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .LOW_LIMIT      (LOW),
        .HIGH_LIMIT     (HIGH)
    ) dut (
        .clock_5   (clock_5),
        .reset     (reset),
        .key1      (key1),
        .tick      (tick),
        .count_in  (count_val),
        .up_down   (up_down),
        .enable_out(enable_out),
        .mode      (mode)
    );

    always #5 clock_5 = ~clock_5;

    // Behavioural 8-bit counter standing in for the datapath.
    always @(posedge clock_5) begin
        if (enable_out) count_val <= up_down ? count_val + 8'd1 : count_val - 8'd1;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed == expected) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    task automatic modelReset();
        m_s1 = 1'b1; m_s2 = 1'b1; m_deb = 1'b1; m_run = 0; m_press = 1'b0;
        m_mode = 2'd0; m_dir = 1'b1; m_en = 1'b0;
    endtask

    // One clock edge of the reference behaviour, taken from the block description.
    task automatic modelStep(input logic k, input logic t, input logic [7:0] c);
        logic       n_deb, n_press, n_dir, n_en;
        logic [1:0] n_mode;
        int         n_run;
        n_deb = m_deb; n_press = 1'b0; n_dir = m_dir; n_en = 1'b0; n_mode = m_mode; n_run = 0;
        if (m_s2 != m_deb) begin
            if (m_run + 1 == DEB) begin
                n_deb = m_s2;
                n_press = ~m_s2;
            end else begin
                n_run = m_run + 1;
            end
        end
        if (t) begin
            if (m_mode == 2'd1) begin n_en = 1'b1; n_dir = 1'b1; end
            if (m_mode == 2'd2) begin n_en = 1'b1; n_dir = 1'b0; end
            if (m_mode == 2'd3) begin
                n_en = 1'b1;
                if (m_dir && c >= HIGH) n_dir = 1'b0;
                else if (!m_dir && c <= LOW) n_dir = 1'b1;
            end
        end
        if (m_press) begin
            n_mode = m_mode + 2'd1;
            if (n_mode == 2'd1 || n_mode == 2'd3) n_dir = 1'b1;
            if (n_mode == 2'd2) n_dir = 1'b0;
        end
        m_s2 = m_s1; m_s1 = k; m_deb = n_deb; m_run = n_run; m_press = n_press;
        m_mode = n_mode; m_dir = n_dir; m_en = n_en;
        sb_q.push_back('{mode: m_mode, up_down: m_dir, en: m_en});
    endtask

    task automatic applyStimulus(input logic k, input logic t);
        exp_t e;
        @(negedge clock_5);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput("sb_mode", int'(mode), int'(e.mode));
            checkOutput("sb_up_down", int'(up_down), int'(e.up_down));
            checkOutput("sb_enable", int'(enable_out), int'(e.en));
        end
        if (t && rec_ticks) tick_counts.push_back(int'(count_val));
        key1 = k;
        tick = t;
        modelStep(k, t, count_val);
    endtask

    task automatic pressKey();
        repeat (10) applyStimulus(1'b0, 1'b0);
        repeat (10) applyStimulus(1'b1, 1'b0);
    endtask

    task automatic tickRun(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b1);
            repeat (3) applyStimulus(1'b1, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pp_exp[12] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
        bit collided;
        reset = 1'b1; key1 = 1'b1; tick = 1'b0;
        modelReset();
        repeat (3) @(negedge clock_5);
        checkOutput("reset_mode", int'(mode), 0);
        checkOutput("reset_up_down", int'(up_down), 1);
        checkOutput("reset_enable", int'(enable_out), 0);
        reset = 1'b0;

        // Short bounce must be rejected.
        repeat (3) applyStimulus(1'b0, 1'b0);
        repeat (12) applyStimulus(1'b1, 1'b0);
        checkOutput("bounce_mode", int'(mode), 0);

        pressKey();
        checkOutput("press1_mode", int'(mode), 1);
        tickRun(3);

        pressKey();
        checkOutput("press2_mode", int'(mode), 2);
        tickRun(3);
        checkOutput("count_after_up_down", int'(count_val), 0);

        pressKey();
        checkOutput("press3_mode", int'(mode), 3);
        rec_ticks = 1'b1;
        tickRun(12);
        rec_ticks = 1'b0;
        checkOutput("pp_tick_total", tick_counts.size(), 12);
        for (int i = 0; i < 12 && i < tick_counts.size(); i++)
            checkOutput($sformatf("pp_count_%0d", i), tick_counts[i], pp_exp[i]);

        pressKey();
        checkOutput("press4_mode", int'(mode), 0);
        tickRun(10);
        checkOutput("stop_count_held", int'(count_val), 2);

        // Drive the tick in the very cycle the press pulse is high.
        collided = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (m_press) collided = 1'b1;
            applyStimulus(1'b0, m_press);
        end
        repeat (10) applyStimulus(1'b1, 1'b0);
        checkOutput("press_tick_coincide", int'(collided), 1);
        checkOutput("collision_mode", int'(mode), 1);
        checkOutput("collision_count_held", int'(count_val), 2);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("post_collision_enable", int'(enable_out), 1);
        repeat (3) applyStimulus(1'b1, 1'b0);

        pressKey();
        pressKey();
        checkOutput("pre_reset_mode", int'(mode), 3);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("pre_reset_enable", int'(enable_out), 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("midrun_reset_mode", int'(mode), 0);
        checkOutput("midrun_reset_up_down", int'(up_down), 1);
        checkOutput("midrun_reset_enable", int'(enable_out), 0);
        sb_q.delete();
        modelReset();
        @(negedge clock_5);
        reset = 1'b0;
        tickRun(5);
        repeat (2) applyStimulus(1'b1, 1'b0);

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
